// File: rtl/deal_control_fsm.sv
// Baccarat deal controller.
// Sequences the six card-load strobes for the datapath, applies the player
// and banker third-card rules from the returned scores, and lights the
// winner once the hand is complete. All outputs are Moore decodes of the
// current state, forced low while resetb is asserted.
module deal_control_fsm (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  typedef enum logic [3:0] {
    S_P1     = 4'd0,
    S_D1     = 4'd1,
    S_P2     = 4'd2,
    S_D2     = 4'd3,
    S_EVAL   = 4'd4,
    S_P3     = 4'd5,
    S_P3EVAL = 4'd6,
    S_D3     = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t state_q;
  state_t state_d;

  // Face cards and tens count zero; 0 means no card dealt and also counts zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    if ((rank >= 4'd1) && (rank <= 4'd9)) begin
      return rank;
    end else begin
      return 4'd0;
    end
  endfunction

  // Banker third-card decision once the player has drawn a third card.
  function automatic logic banker_draws(input logic [3:0] bscore,
                                        input logic [3:0] v);
    logic draw;
    case (bscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  // Next-state logic: fixed deal order, then the drawing rules.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_P1: state_d = S_D1;
      S_D1: state_d = S_P2;
      S_P2: state_d = S_D2;
      S_D2: state_d = S_EVAL;
      S_EVAL: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
          state_d = S_DONE;
        end else if (pscore <= 4'd5) begin
          state_d = S_P3;
        end else if (dscore <= 4'd5) begin
          state_d = S_D3;
        end else begin
          state_d = S_DONE;
        end
      end
      S_P3: state_d = S_P3EVAL;
      S_P3EVAL: begin
        if (banker_draws(dscore, card_value(pcard3))) begin
          state_d = S_D3;
        end else begin
          state_d = S_DONE;
        end
      end
      S_D3:   state_d = S_DONE;
      S_DONE: state_d = S_DONE;
      default: state_d = S_P1;
    endcase
  end

  // State register; reset returns the deal to the first player card.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_P1;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode; gated by resetb so every output is low during reset.
  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    if (resetb) begin
      case (state_q)
        S_P1: load_pcard1 = 1'b1;
        S_D1: load_dcard1 = 1'b1;
        S_P2: load_pcard2 = 1'b1;
        S_D2: load_dcard2 = 1'b1;
        S_P3: load_pcard3 = 1'b1;
        S_D3: load_dcard3 = 1'b1;
        S_DONE: begin
          player_win_light = (pscore >= dscore);
          dealer_win_light = (dscore >= pscore);
        end
        default: begin
          load_pcard1 = 1'b0;
        end
      endcase
    end else begin
      load_pcard1 = 1'b0;
    end
  end

endmodule

// File: tb/tb_deal_control_fsm.sv
// Self-checking bench for deal_control_fsm: table of hands with
// expected outputs pushed to a scoreboard queue as each cycle is driven,
// popped and compared on the falling edge; plus reset corner sequences.
module tb_deal_control_fsm;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int n_cmp = 0;
  int n_bad = 0;

  // Output word order: {p1, d1, p2, d2, p3, d3, player, dealer}
  localparam logic [7:0] O_P1 = 8'b1000_0000;
  localparam logic [7:0] O_D1 = 8'b0100_0000;
  localparam logic [7:0] O_P2 = 8'b0010_0000;
  localparam logic [7:0] O_D2 = 8'b0001_0000;
  localparam logic [7:0] O_P3 = 8'b0000_1000;
  localparam logic [7:0] O_D3 = 8'b0000_0100;
  localparam logic [7:0] O_NONE = 8'b0000_0000;

  typedef struct {
    string      name;
    logic [3:0] ep, ed;   // scores at evaluation after four cards
    logic [3:0] pc3, p3s; // player third card rank and resulting pscore
    logic [3:0] fp, fd;   // final scores in the done state
    logic       p3, d3;   // expected third-card draws
    logic       pw, dw;   // expected lights
  } hand_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  sb_t   sb_q[$];
  hand_t tbl[11];

  deal_control_fsm dut (
    .slow_clock      (slow_clock),
    .resetb          (resetb),
    .pscore          (pscore),
    .dscore          (dscore),
    .pcard3          (pcard3),
    .load_pcard1     (load_pcard1),
    .load_pcard2     (load_pcard2),
    .load_pcard3     (load_pcard3),
    .load_dcard1     (load_dcard1),
    .load_dcard2     (load_dcard2),
    .load_dcard3     (load_dcard3),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic logic [7:0] dut_word();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
            load_pcard3, load_dcard3, player_win_light, dealer_win_light};
  endfunction

  function automatic hand_t mk(string name, logic [3:0] ep, logic [3:0] ed,
                               logic [3:0] pc3, logic [3:0] p3s,
                               logic [3:0] fp, logic [3:0] fd,
                               logic p3, logic d3, logic pw, logic dw);
    hand_t h;
    h.name = name; h.ep = ep; h.ed = ed; h.pc3 = pc3; h.p3s = p3s;
    h.fp = fp; h.fd = fd; h.p3 = p3; h.d3 = d3; h.pw = pw; h.dw = dw;
    return h;
  endfunction

  task automatic push(string name, logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the DUT now.
  task automatic pop_check();
    sb_t e;
    logic [7:0] act;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: actual queue size 0, required >0");
    end else begin
      e = sb_q.pop_front();
      act = dut_word();
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: actual %b required %b (p1 d1 p2 d2 p3 d3 pw dw)",
                 e.name, act, e.exp);
      end
    end
  endtask

  // Sample one cycle: expectation goes in at drive time, compare at negedge.
  task automatic sample(string name, logic [7:0] exp);
    push(name, exp);
    @(negedge slow_clock);
    pop_check();
  endtask

  task automatic next_cycle();
    @(posedge slow_clock);
    #1;
  endtask

  // Reset with the clock running; outputs must stay low throughout.
  task automatic do_reset(string name);
    next_cycle();
    resetb = 1'b0;
    sample({name, "_rst0"}, O_NONE);
    next_cycle();
    sample({name, "_rst1"}, O_NONE);
    next_cycle();
    resetb = 1'b1;
  endtask

  task automatic run_hand(hand_t h);
    int   k;
    int   p3_cyc;
    int   d3_cyc;
    int   done_cyc;
    logic [7:0] exp;
    pscore = h.ep;
    dscore = h.ed;
    pcard3 = 4'd0;
    do_reset(h.name);
    p3_cyc   = h.p3 ? 5 : -1;
    d3_cyc   = h.d3 ? (h.p3 ? 7 : 5) : -1;
    done_cyc = 5 + (h.p3 ? 2 : 0) + (h.d3 ? 1 : 0);
    for (k = 0; k < done_cyc + 10; k++) begin
      if (k == 6 && h.p3) begin
        pcard3 = h.pc3;
        pscore = h.p3s;
      end
      if (k == done_cyc) begin
        pscore = h.fp;
        dscore = h.fd;
      end
      case (k)
        0: exp = O_P1;
        1: exp = O_D1;
        2: exp = O_P2;
        3: exp = O_D2;
        default: begin
          if (k == p3_cyc)        exp = O_P3;
          else if (k == d3_cyc)   exp = O_D3;
          else if (k >= done_cyc) exp = {6'b000000, h.pw, h.dw};
          else                    exp = O_NONE;
        end
      endcase
      sample($sformatf("%s_c%0d", h.name, k), exp);
      next_cycle();
    end
  endtask

  initial begin
    //          name        ep     ed     pc3    p3s    fp     fd    p3    d3    pw    dw
    tbl[0]  = mk("natural", 4'd8, 4'd3, 4'd0,  4'd8, 4'd8, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk("tie_nat", 4'd9, 4'd9, 4'd0,  4'd9, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[2]  = mk("b6_v6",   4'd4, 4'd6, 4'd6,  4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[3]  = mk("b6_v8",   4'd4, 4'd6, 4'd8,  4'd2, 4'd2, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk("b3_q",    4'd2, 4'd3, 4'd12, 4'd2, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[5]  = mk("b4_q",    4'd2, 4'd4, 4'd12, 4'd2, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk("b3_v8",   4'd1, 4'd3, 4'd8,  4'd9, 4'd9, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk("p6_b5",   4'd6, 4'd5, 4'd0,  4'd6, 4'd6, 4'd6, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[8]  = mk("p6_b7",   4'd6, 4'd7, 4'd0,  4'd6, 4'd6, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk("b7_std",  4'd5, 4'd7, 4'd5,  4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk("b0_k",    4'd3, 4'd0, 4'd13, 4'd3, 4'd3, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);

    foreach (tbl[i]) run_hand(tbl[i]);

    // Mid-deal reset pulse during S_D2: strobes drop at once, deal restarts.
    pscore = 4'd4;
    dscore = 4'd6;
    pcard3 = 4'd0;
    do_reset("midrst");
    sample("midrst_p1", O_P1);
    next_cycle();
    sample("midrst_d1", O_D1);
    next_cycle();
    sample("midrst_p2", O_P2);
    next_cycle();
    sample("midrst_d2", O_D2);
    #1;
    resetb = 1'b0;
    #1;
    push("midrst_async_low", O_NONE);
    pop_check();
    next_cycle();
    sample("midrst_held", O_NONE);
    next_cycle();
    resetb = 1'b1;
    #1;
    push("midrst_release_p1", O_P1);
    pop_check();
    sample("midrst_re_p1", O_P1);
    next_cycle();
    sample("midrst_re_d1", O_D1);
    next_cycle();
    sample("midrst_re_p2", O_P2);
    next_cycle();
    sample("midrst_re_d2", O_D2);

    // Reset in the done state drops the lights asynchronously.
    pscore = 4'd9;
    dscore = 4'd2;
    next_cycle();
    sample("done_eval", O_NONE);
    next_cycle();
    sample("done_lights", 8'b0000_0010);
    #1;
    resetb = 1'b0;
    #1;
    push("done_async_low", O_NONE);
    pop_check();
    next_cycle();
    resetb = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
